instr_fetch_unit: RTL and testbench

Upstream stage of `instruction_decoder`. It holds the program counter, issues word fetches on a single-outstanding request/grant/response instruction-memory port, and buffers returned instructions with their PCs in a small FIFO. It presents one instruction per cycle to the decoder under a valid/ready handshake. Branch/jump redirects flush the buffer and discard any in-flight response.

---
 rtl/instr_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem port and an instruction FIFO for the decoder.
// Define IFU_BYPASS_EN to forward a response straight to the decoder when the FIFO is empty.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [31:0]      pc_reg, pc_next;
    logic [31:0]      req_pc_reg, req_pc_next;
    logic             kill_reg, kill_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [PTR_W-1:0] rd_ptr_reg, wr_ptr_reg;
    logic             imem_req_reg;
    logic [31:0]      imem_addr_reg;
    logic [31:0]      fifo_instr_mem [FIFO_DEPTH];
    logic [31:0]      fifo_pc_mem    [FIFO_DEPTH];

    logic fifo_valid, resp_ok, bypass_take, push, pop;
    logic [1:0] redirect_low_unused;

    assign redirect_low_unused = redirect_pc[1:0];
    assign fifo_valid = (count_reg != '0);
    // A response is usable only while waiting for it, not killed, and not racing a redirect.
    assign resp_ok    = (state_reg == ST_WAIT) && imem_rvalid && !kill_reg && !redirect_valid;

`ifdef IFU_BYPASS_EN
    logic bypass_valid;
    assign bypass_valid = resp_ok && !fifo_valid;
    assign bypass_take  = bypass_valid && instr_ready;
`else
    assign bypass_take  = 1'b0;
`endif

    assign push = resp_ok && !bypass_take;
    assign pop  = fifo_valid && instr_ready && !redirect_valid;

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_pc_next = req_pc_reg;
        kill_next   = kill_reg;
        count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        case (state_reg)
            ST_IDLE: begin
                if (count_reg < DEPTH_C) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (imem_gnt) begin
                    state_next  = ST_WAIT;
                    req_pc_next = imem_addr_reg;
                    // A killed request was issued from the old stream; pc already holds the target.
                    if (!kill_reg) pc_next = pc_reg + 32'd4;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    kill_next  = 1'b0;
                    state_next = (count_next < DEPTH_C) ? ST_REQ : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (redirect_valid) begin
            count_next = '0;
            pc_next    = {redirect_pc[31:2], 2'b00};
            case (state_reg)
                ST_IDLE: state_next = ST_REQ;
                ST_REQ:  kill_next  = 1'b1;
                ST_WAIT: begin
                    if (imem_rvalid) state_next = ST_REQ;
                    else             kill_next  = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            pc_reg        <= RESET_PC;
            req_pc_reg    <= RESET_PC;
            kill_reg      <= 1'b0;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            req_pc_reg   <= req_pc_next;
            kill_reg     <= kill_next;
            count_reg    <= count_next;
            imem_req_reg <= (state_next == ST_REQ);
            // Address is latched only on entry to REQ so it stays stable until granted.
            if (state_next == ST_REQ && state_reg != ST_REQ) imem_addr_reg <= pc_next;
            if (redirect_valid) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_mem[wr_ptr_reg] <= imem_rdata;
            fifo_pc_mem[wr_ptr_reg]    <= req_pc_reg;
        end
    end

    assign imem_req  = imem_req_reg;
    assign imem_addr = imem_addr_reg;

    always_comb begin
        instr_valid = fifo_valid;
        instr       = 32'd0;
        instr_pc    = 32'd0;
        if (fifo_valid) begin
            instr    = fifo_instr_mem[rd_ptr_reg];
            instr_pc = fifo_pc_mem[rd_ptr_reg];
        end
`ifdef IFU_BYPASS_EN
        else if (bypass_valid) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = req_pc_reg;
        end
`endif
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: the expected instruction stream is the sequential
// program order from the last reset/redirect target; memory returns a fixed hash of the address.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
`ifdef IFU_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk, rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr, instr_pc;

    instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int hs_count = 0;

    typedef struct packed { logic [31:0] pc; logic [31:0] data; } exp_t;
    exp_t        sb_q[$];
    logic [31:0] sb_next;
    logic [31:0] grant_log[$];

    // Driver knobs: mode 0 = never, 1 = always, 2 = random.
    int          gnt_mode, ready_mode, lat_min, lat_max;
    logic        rst_drive, redir_req;
    logic [31:0] redir_tgt;
    logic        pend, prev_stall;
    logic [31:0] pend_addr, prev_addr;
    int          pend_cnt;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0000_0013;
    endfunction

    function automatic logic [31:0] glog(input int i);
        if (i < grant_log.size()) return grant_log[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic sb_restart(input logic [31:0] target);
        sb_q.delete();
        sb_next = {target[31:2], 2'b00};
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_imem_req"},    imem_req,    0);
        check({tag, "_imem_addr"},   imem_addr,   RST_PC);
        check({tag, "_instr_valid"}, instr_valid, 0);
        check({tag, "_instr"},       instr,       0);
        check({tag, "_instr_pc"},    instr_pc,    0);
    endtask

    // One clock cycle: drive inputs at the falling edge, then observe what the next rising edge commits.
    task automatic step();
        @(negedge clk);
        rst_n = rst_drive;
        if (!rst_drive) begin
            sb_restart(RST_PC);
            grant_log.delete();
        end
        if (pend && pend_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        imem_gnt    = (gnt_mode == 1) || (gnt_mode == 2 && $urandom_range(0, 9) < 7);
        instr_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 9) < 6);
        redirect_valid = redir_req;
        redirect_pc    = redir_req ? redir_tgt : $urandom;
        if (redir_req) sb_restart(redir_tgt);
        redir_req = 1'b0;
        while (sb_q.size() < 16) begin
            sb_q.push_back({sb_next, mem_word(sb_next)});
            sb_next += 32'd4;
        end
        #1;
        if (prev_stall && rst_n)
            check("req_hold", {31'b0, imem_req, imem_addr}, {31'b0, 1'b1, prev_addr});
        prev_stall = rst_n && imem_req && !imem_gnt;
        prev_addr  = imem_addr;
        if (imem_rvalid) pend = 1'b0;
        else if (pend) pend_cnt--;
        if (imem_req && imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_cnt  = int'($urandom_range(lat_min, lat_max)) - 1;
            grant_log.push_back(imem_addr);
            $display("fetch granted addr=%h", imem_addr);
        end
    endtask

    task automatic reset_pulse();
        rst_drive = 1'b0;
        repeat (2) step();
        rst_drive = 1'b1;
        step();
    endtask

    // Monitor: every accepted instruction must be the next one in program order.
    always @(negedge clk) begin
        #2;
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                $display("FAIL sb_underflow: got pc=%h, expected no instruction", instr_pc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("instr", {instr_pc, instr}, {e.pc, e.data});
                hs_count++;
                $display("instr accepted pc=%h data=%h", instr_pc, instr);
            end
        end
    end

    initial begin
        int idx, reqs, hs0;
        rst_n = 1'b0; rst_drive = 1'b0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        redir_req = 1'b0; redir_tgt = '0; pend = 1'b0; pend_addr = '0; pend_cnt = 0;
        prev_stall = 1'b0; prev_addr = '0; sb_next = RST_PC;
        gnt_mode = 1; ready_mode = 1; lat_min = 1; lat_max = 1;

        repeat (3) step();
        check_reset("rst");

        // Reset then fetch, 1-cycle memory.
        rst_drive = 1'b1;
        step();
        check("req_low_release", imem_req, 0);
        step();
        check("req_high_2nd", imem_req, 1);
        check("first_addr", imem_addr, RST_PC);
        step();
        check("resp_same_cycle_valid", instr_valid, BYP);
        step();
        check("resp_next_cycle_valid", instr_valid, !BYP);
        repeat (10) step();
        check("addr0", glog(0), 32'h100);
        check("addr1", glog(1), 32'h104);
        check("addr2", glog(2), 32'h108);

        // Backpressure: four fetches fill the buffer, then the port idles.
        reset_pulse();
        ready_mode = 0;
        repeat (30) step();
        check("bp_fetches", grant_log.size(), 4);
        reqs = 0;
        repeat (10) begin step(); reqs += imem_req; end
        check("bp_idle_req", reqs, 0);
        check("bp_valid", instr_valid, 1);
        ready_mode = 1;
        step();
        ready_mode = 0;
        repeat (20) step();
        check("bp_one_refetch", grant_log.size(), 5);
        check("bp_idle_again", imem_req, 0);

        // Redirect while the 0x108 fetch is pending.
        reset_pulse();
        ready_mode = 1; lat_min = 3; lat_max = 3;
        for (int i = 0; i < 60 && grant_log.size() < 3; i++) step();
        check("wait_pending_addr", glog(2), 32'h108);
        redir_req = 1'b1; redir_tgt = 32'h2003;
        idx = grant_log.size();
        step();
        step();
        check("redir_flush", instr_valid, 0);
        repeat (20) step();
        check("redir_wait_next", glog(idx), 32'h2000);

        // Redirect in REQ while the grant is stalled.
        lat_min = 1; lat_max = 1;
        gnt_mode = 0;
        reset_pulse();
        repeat (4) step();
        redir_req = 1'b1; redir_tgt = 32'h400;
        step();
        repeat (3) step();
        check("stall_addr", imem_addr, RST_PC);
        gnt_mode = 1;
        repeat (10) step();
        check("stalled_grant", glog(0), RST_PC);
        check("redir_req_next", glog(1), 32'h400);

        // Reset mid-operation: three buffered entries and one response pending.
        reset_pulse();
        ready_mode = 0; lat_min = 4; lat_max = 4;
        for (int i = 0; i < 80 && grant_log.size() < 4; i++) step();
        check("midrst_grants", grant_log.size(), 4);
        rst_drive = 1'b0;
        step();
        check_reset("midrst");
        step();
        rst_drive = 1'b1;
        step();
        repeat (3) begin
            step();
            check("late_rvalid", instr_valid, 0);
        end

        // Randomised traffic with redirects, including targets that wrap past 0xFFFF_FFFC.
        reset_pulse();
        gnt_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 3;
        hs0 = hs_count;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) begin
                redir_req = 1'b1;
                redir_tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF4 : $urandom;
            end
            step();
        end
        check("progress", (hs_count - hs0) > 200, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
